ret_stack: RTL and testbench
============================

Name: ret_stack

Overview:
- Return-address stack for the single-cycle CPU. It consumes the control unit's push/pop strobes and stores return addresses (PC+1) on subroutine call.
- It presents the top entry combinationally, so the PC mux (selected by s_stack) can load it as next PC in the same cycle as a return.
- Sits between the PC incrementer and the PC next-address mux.

Parameters:
- WIDTH, 10, PC/return-address width in bits.
- DEPTH, 16, number of stack entries; power of two, >= 2.
- PW, $clog2(DEPTH)+1, pointer/count width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  from control unit: store din on top at next edge.
- pop  in  1  from control unit: discard top at next edge.
- din  in  WIDTH  return address to store (PC+1 from incrementer).
- dout  out  WIDTH  current top entry, combinational; 0 when empty.
- count  out  PW  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: push attempted while full (no simultaneous pop).
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset=0, async): sp/count=0, overflow=0, underflow=0. Storage contents are don't-care. Outputs: dout=0, empty=1, full=0. While reset is low, all strobes are ignored.
- Storage: DEPTH x WIDTH registers. Stack pointer sp = count. Top entry = mem[sp-1].
- dout = empty ? 0 : mem[sp-1]. Purely combinational, so zero-latency for a return. A pushed value is visible on dout the cycle after its push edge.
- Per rising edge, by {push,pop}:
  - 00: hold.
  - 10, not full: mem[sp]<=din; sp<=sp+1.
  - 10, full: no write; sp unchanged; overflow<=1.
  - 01, not empty: sp<=sp-1. The storage entry is not cleared.
  - 01, empty: sp stays 0; underflow<=1.
  - 11, not empty: replace top, i.e. mem[sp-1]<=din; sp unchanged. No flag change, even when full.
  - 11, empty: mem[0]<=din; sp<=1; underflow<=1.
- Sticky flags: once set, they stay set until reset; no other clear.
- No wrap-around: sp never exceeds DEPTH and never goes below 0.
- Reset asserted mid-sequence discards all entries immediately (async). The first edge after deassertion behaves as from empty.
- empty, full and count derive from registered sp only; there is no combinational path from push/pop to them.
- No combinational path from push/pop to dout; dout depends only on registered state.

Test Plan:
- Reset then idle: reset low 2 cycles, release -> dout=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- LIFO order: push din=0x005, 0x012, 0x3FF on 3 edges, then pop x3.
  - Before the pops: dout=0x3FF, count=3.
  - After each pop edge: dout=0x012, then 0x005, then 0 with empty=1.
  - underflow stays 0.
- Fill and overflow, DEPTH=16: push 0x100..0x10F (16 edges) -> full=1, dout=0x10F. A 17th push of 0x1AA -> dout=0x10F, count=16, overflow=1.
- Underflow: from empty, pop 1 edge -> count=0, underflow=1, dout=0. A following push of 0x020 -> dout=0x020, underflow still 1.
- Simultaneous: stack holds 0x005,0x012; push&pop with din=0x0AB -> count=2, dout=0x0AB. Then pop -> dout=0x005. Push&pop when empty with din=0x033 -> count=1, dout=0x033, underflow=1.
- Async reset mid-operation: stack holds 5 entries and overflow=1; drop reset between edges -> immediately count=0, empty=1, overflow=0, dout=0. After release, push 0x001 -> dout=0x001, count=1.

Source files
------------

// File: rtl/ret_stack.sv
// Return-address stack: LIFO of DEPTH entries whose top entry is presented
// combinationally, so a return can load it as next PC in the same cycle.
module ret_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp_reg;
    logic [PW-1:0]    sp_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic             underflow_reg;
    logic             underflow_next;
    logic [AW-1:0]    top_idx;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    assign empty     = (sp_reg == '0);
    assign full      = (sp_reg == PW'(DEPTH));
    assign count     = sp_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign top_idx   = AW'(sp_reg - PW'(1));
    assign dout      = empty ? '0 : mem[top_idx];

    always_comb begin
        sp_next        = sp_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        wr_en          = 1'b0;
        wr_addr        = sp_reg[AW-1:0];
        unique case ({push, pop})
            2'b10: begin
                if (full) begin
                    overflow_next = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    sp_next = sp_reg + PW'(1);
                end
            end
            2'b01: begin
                if (empty) underflow_next = 1'b1;
                else       sp_next        = sp_reg - PW'(1);
            end
            2'b11: begin
                wr_en = 1'b1;
                if (empty) begin
                    // Pop of nothing still counts as underflow; the push lands in slot 0.
                    wr_addr        = '0;
                    sp_next        = PW'(1);
                    underflow_next = 1'b1;
                end else begin
                    wr_addr = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_reg        <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp_reg        <= sp_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage has no reset; writes are simply suppressed while reset is held.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset && wr_en && (wr_addr == AW'(gi))) begin
                mem[gi] <= din;
            end
        end
    end
endmodule

// File: tb/tb_ret_stack.sv
// Directed self-checking bench for ret_stack (WIDTH=10, DEPTH=16).
module tb_ret_stack;
    localparam int WIDTH = 10;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic [PW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .dout(dout), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks++;
        if (obs !== exp_val) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // One clock edge with the given strobes; returns 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q, input logic [WIDTH-1:0] d);
        push = p;
        pop  = q;
        din  = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);

        // LIFO order
        cyc(1, 0, 10'h005);
        check("push1_dout", 32'(dout), 32'h005);
        cyc(1, 0, 10'h012);
        cyc(1, 0, 10'h3FF);
        check("lifo_top", 32'(dout), 32'h3FF);
        check("lifo_count", 32'(count), 32'd3);
        cyc(0, 1, '0);
        check("pop1_dout", 32'(dout), 32'h012);
        cyc(0, 1, '0);
        check("pop2_dout", 32'(dout), 32'h005);
        cyc(0, 1, '0);
        check("pop3_dout", 32'(dout), 32'h0);
        check("pop3_empty", 32'(empty), 32'd1);
        check("lifo_unf", 32'(underflow), 32'd0);

        // Fill and overflow
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 10'(10'h100 + i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_dout", 32'(dout), 32'h10F);
        check("fill_ovf0", 32'(overflow), 32'd0);
        cyc(1, 0, 10'h1AA);
        check("ovf_dout", 32'(dout), 32'h10F);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);

        // Drain, then underflow
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, '0);
        check("drain_count", 32'(count), 32'd0);
        check("drain_ovf", 32'(overflow), 32'd1);
        cyc(0, 1, '0);
        check("unf_count", 32'(count), 32'd0);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_dout", 32'(dout), 32'h0);
        cyc(1, 0, 10'h020);
        check("unf_push_dout", 32'(dout), 32'h020);
        check("unf_sticky", 32'(underflow), 32'd1);

        // Simultaneous push & pop
        do_reset();
        cyc(1, 0, 10'h005);
        cyc(1, 0, 10'h012);
        cyc(1, 1, 10'h0AB);
        check("sim_count", 32'(count), 32'd2);
        check("sim_dout", 32'(dout), 32'h0AB);
        check("sim_unf", 32'(underflow), 32'd0);
        cyc(0, 1, '0);
        check("sim_pop_dout", 32'(dout), 32'h005);
        cyc(0, 1, '0);
        cyc(1, 1, 10'h033);
        check("sim_emp_count", 32'(count), 32'd1);
        check("sim_emp_dout", 32'(dout), 32'h033);
        check("sim_emp_unf", 32'(underflow), 32'd1);

        // Replace top while full: no flag change
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 10'(10'h200 + i));
        cyc(1, 1, 10'h155);
        check("fullrep_dout", 32'(dout), 32'h155);
        check("fullrep_count", 32'(count), 32'd16);
        check("fullrep_ovf", 32'(overflow), 32'd0);
        cyc(0, 1, '0);
        check("fullrep_pop", 32'(dout), 32'h20E);

        // Async reset mid-operation: 5 entries held, overflow set
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 10'(10'h300 + i));
        cyc(1, 0, 10'h0EE);
        for (int i = 0; i < DEPTH - 5; i++) cyc(0, 1, '0);
        check("pre_arst_count", 32'(count), 32'd5);
        check("pre_arst_dout", 32'(dout), 32'h304);
        check("pre_arst_ovf", 32'(overflow), 32'd1);
        reset = 1'b0;
        #2;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_dout", 32'(dout), 32'h0);
        cyc(1, 0, 10'h077);
        check("arst_hold_count", 32'(count), 32'd0);
        reset = 1'b1;
        cyc(1, 0, 10'h001);
        check("post_arst_dout", 32'(dout), 32'h001);
        check("post_arst_count", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
